// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the VGA pointer / host logic and the display register bank arbiter.
// master = requesters' side, slave = arbiter side.
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              Blank;
    logic [ADDR_W-1:0] VgaAddr;
    logic [DATA_W-1:0] VgaData;
    logic              HostReq;
    logic              HostWe;
    logic [ADDR_W-1:0] HostAddr;
    logic [DATA_W-1:0] HostWData;
    logic [DATA_W-1:0] HostRData;
    logic              HostAck;
    logic              Stolen;

    modport master (
        output Blank, VgaAddr, HostReq, HostWe, HostAddr, HostWData,
        input  VgaData, HostRData, HostAck, Stolen
    );

    modport slave (
        input  Blank, VgaAddr, HostReq, HostWe, HostAddr, HostWData,
        output VgaData, HostRData, HostAck, Stolen
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-ported 2^ADDR_W x DATA_W display bank shared by the per-cycle VGA read path
// and a 4-phase req/ack host port; host gets the port during blanking or after MAX_WAIT.
module vga_mem_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 800,
    parameter int WAIT_W   = 10
) (
    input  logic               CLK,
    input  logic               RESET,
    vga_mem_arbiter_if.slave   bus
);
    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_waitcnt;
    logic                r_req_we;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [DATA_W-1:0]   r_bank [DEPTH];
    logic [DATA_W-1:0]   r_vga_data;
    logic [DATA_W-1:0]   r_host_rdata;
    logic                r_host_ack;
    logic                r_stolen;
    logic                w_grant;

    // Grant during blanking, or forced once the host has waited MAX_WAIT cycles.
    assign w_grant = (r_state == IDLE) && bus.HostReq &&
                     (bus.Blank || (r_waitcnt == MAX_CNT));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next = ACCESS;
            ACCESS:  w_next = ACK;
            ACK:     if (!bus.HostReq) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_waitcnt   <= '0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_host_ack  <= 1'b0;
            r_stolen    <= 1'b0;
        end else begin
            if (!bus.HostReq || w_grant)
                r_waitcnt <= '0;
            else if (r_state == IDLE && r_waitcnt != MAX_CNT)
                r_waitcnt <= r_waitcnt + WAIT_W'(1);

            if (w_grant) begin
                r_req_we    <= bus.HostWe;
                r_req_addr  <= bus.HostAddr;
                r_req_wdata <= bus.HostWData;
            end

            r_host_ack <= (w_next == ACK);
            r_stolen   <= w_grant && !bus.Blank;
        end
    end

    // The host owns the port only in ACCESS; the VGA read path holds its data there.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
            r_vga_data   <= '0;
            r_host_rdata <= '0;
        end else if (r_state == ACCESS) begin
            if (r_req_we) r_bank[r_req_addr] <= r_req_wdata;
            else          r_host_rdata       <= r_bank[r_req_addr];
        end else begin
            r_vga_data <= r_bank[bus.VgaAddr];
        end
    end

    assign bus.VgaData   = r_vga_data;
    assign bus.HostRData = r_host_rdata;
    assign bus.HostAck   = r_host_ack;
    assign bus.Stolen    = r_stolen;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: host write/read in blanking, forced steal,
// abandoned request, blank falling at grant, and reset in the middle of an access.
module tb_vga_mem_arbiter;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 800;
    localparam int WAIT_W   = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        n_cmp++; if (bus.VgaData !== 8'h00) begin n_err++; $display("FAIL reset_vga got %h want 00", bus.VgaData); end
        n_cmp++; if (bus.HostRData !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h want 00", bus.HostRData); end
        n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", bus.HostAck); end
        n_cmp++; if (bus.Stolen !== 1'b0) begin n_err++; $display("FAIL reset_stolen got %b want 0", bus.Stolen); end
    endtask

    task automatic test_write;
        bus.Blank = 1'b1; bus.HostReq = 1'b1; bus.HostWe = 1'b1;
        bus.HostAddr = 4'd3; bus.HostWData = 8'hA5;
        tick;   // grant edge
        n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL wr_ack_early got %b want 0", bus.HostAck); end
        n_cmp++; if (bus.Stolen !== 1'b0) begin n_err++; $display("FAIL wr_stolen got %b want 0", bus.Stolen); end
        tick;   // ACCESS -> ACK
        n_cmp++; if (bus.HostAck !== 1'b1) begin n_err++; $display("FAIL wr_ack got %b want 1", bus.HostAck); end
        bus.HostReq = 1'b0;
        tick;
        n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL wr_ack_fall got %b want 0", bus.HostAck); end
        bus.Blank = 1'b0; bus.VgaAddr = 4'd3;
        tick;
        n_cmp++; if (bus.VgaData !== 8'hA5) begin n_err++; $display("FAIL wr_vga got %h want a5", bus.VgaData); end
        n_cmp++; if (bus.Stolen !== 1'b0) begin n_err++; $display("FAIL wr_stolen2 got %b want 0", bus.Stolen); end
    endtask

    task automatic test_read;
        bus.Blank = 1'b1; bus.HostReq = 1'b1; bus.HostWe = 1'b0; bus.HostAddr = 4'd3;
        tick; tick;
        n_cmp++; if (bus.HostAck !== 1'b1) begin n_err++; $display("FAIL rd_ack got %b want 1", bus.HostAck); end
        n_cmp++; if (bus.HostRData !== 8'hA5) begin n_err++; $display("FAIL rd_data got %h want a5", bus.HostRData); end
        for (int i = 0; i < 10; i++) begin
            tick;
            n_cmp++; if (bus.HostAck !== 1'b1) begin n_err++; $display("FAIL rd_ack_hold[%0d] got %b want 1", i, bus.HostAck); end
        end
        bus.HostReq = 1'b0;
        tick;
        n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL rd_ack_fall got %b want 0", bus.HostAck); end
        n_cmp++; if (bus.HostRData !== 8'hA5) begin n_err++; $display("FAIL rd_data_stable got %h want a5", bus.HostRData); end
    endtask

    task automatic test_steal;
        bus.Blank = 1'b0; bus.VgaAddr = 4'd3;
        bus.HostReq = 1'b1; bus.HostWe = 1'b1; bus.HostAddr = 4'd5; bus.HostWData = 8'h3C;
        for (int i = 0; i < MAX_WAIT; i++) tick;
        n_cmp++; if (bus.Stolen !== 1'b0) begin n_err++; $display("FAIL steal_early got %b want 0", bus.Stolen); end
        n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL steal_ack_early got %b want 0", bus.HostAck); end
        tick;   // forced grant edge
        n_cmp++; if (bus.Stolen !== 1'b1) begin n_err++; $display("FAIL steal_pulse got %b want 1", bus.Stolen); end
        n_cmp++; if (bus.VgaData !== 8'hA5) begin n_err++; $display("FAIL steal_vga got %h want a5", bus.VgaData); end
        bus.VgaAddr = 4'd0;
        tick;   // ACCESS: VGA data frozen
        n_cmp++; if (bus.Stolen !== 1'b0) begin n_err++; $display("FAIL steal_pulse_end got %b want 0", bus.Stolen); end
        n_cmp++; if (bus.VgaData !== 8'hA5) begin n_err++; $display("FAIL steal_freeze got %h want a5", bus.VgaData); end
        n_cmp++; if (bus.HostAck !== 1'b1) begin n_err++; $display("FAIL steal_ack got %b want 1", bus.HostAck); end
        tick;
        n_cmp++; if (bus.VgaData !== 8'h00) begin n_err++; $display("FAIL steal_vga_resume got %h want 00", bus.VgaData); end
        n_cmp++; if (dut.r_waitcnt !== 10'd0) begin n_err++; $display("FAIL steal_cnt got %0d want 0", dut.r_waitcnt); end
        bus.HostReq = 1'b0; bus.VgaAddr = 4'd5;
        tick;
        n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL steal_ack_fall got %b want 0", bus.HostAck); end
        n_cmp++; if (bus.VgaData !== 8'h3C) begin n_err++; $display("FAIL steal_wr got %h want 3c", bus.VgaData); end
    endtask

    task automatic test_abandon;
        bus.Blank = 1'b0; bus.HostReq = 1'b1; bus.HostWe = 1'b1;
        bus.HostAddr = 4'd7; bus.HostWData = 8'h77;
        for (int i = 0; i < 5; i++) tick;
        n_cmp++; if (dut.r_waitcnt !== 10'd5) begin n_err++; $display("FAIL ab_cnt got %0d want 5", dut.r_waitcnt); end
        bus.HostReq = 1'b0;
        tick;
        n_cmp++; if (dut.r_waitcnt !== 10'd0) begin n_err++; $display("FAIL ab_cnt_clr got %0d want 0", dut.r_waitcnt); end
        bus.Blank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL ab_ack[%0d] got %b want 0", i, bus.HostAck); end
        end
        bus.VgaAddr = 4'd7;
        tick;
        n_cmp++; if (bus.VgaData !== 8'h00) begin n_err++; $display("FAIL ab_bank got %h want 00", bus.VgaData); end
    endtask

    task automatic test_blank_fall;
        bus.Blank = 1'b1; bus.VgaAddr = 4'd3;
        bus.HostReq = 1'b1; bus.HostWe = 1'b1; bus.HostAddr = 4'd9; bus.HostWData = 8'h5A;
        tick;   // grant taken while Blank=1
        bus.Blank = 1'b0;
        n_cmp++; if (bus.Stolen !== 1'b0) begin n_err++; $display("FAIL bf_stolen got %b want 0", bus.Stolen); end
        n_cmp++; if (bus.VgaData !== 8'hA5) begin n_err++; $display("FAIL bf_vga got %h want a5", bus.VgaData); end
        bus.VgaAddr = 4'd9;
        tick;   // ACCESS
        n_cmp++; if (bus.VgaData !== 8'hA5) begin n_err++; $display("FAIL bf_freeze got %h want a5", bus.VgaData); end
        n_cmp++; if (bus.HostAck !== 1'b1) begin n_err++; $display("FAIL bf_ack got %b want 1", bus.HostAck); end
        n_cmp++; if (bus.Stolen !== 1'b0) begin n_err++; $display("FAIL bf_stolen2 got %b want 0", bus.Stolen); end
        tick;
        n_cmp++; if (bus.VgaData !== 8'h5A) begin n_err++; $display("FAIL bf_raw got %h want 5a", bus.VgaData); end
        bus.HostReq = 1'b0;
        tick;
        n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL bf_ack_fall got %b want 0", bus.HostAck); end
    endtask

    task automatic test_reset_mid;
        bus.Blank = 1'b1; bus.VgaAddr = 4'd3;
        bus.HostReq = 1'b1; bus.HostWe = 1'b1; bus.HostAddr = 4'd3; bus.HostWData = 8'hFF;
        tick;   // now in ACCESS
        n_cmp++; if (bus.VgaData !== 8'hA5) begin n_err++; $display("FAIL rm_pre_vga got %h want a5", bus.VgaData); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.VgaData !== 8'h00) begin n_err++; $display("FAIL rm_vga got %h want 00", bus.VgaData); end
        n_cmp++; if (bus.HostRData !== 8'h00) begin n_err++; $display("FAIL rm_rdata got %h want 00", bus.HostRData); end
        n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL rm_ack got %b want 0", bus.HostAck); end
        n_cmp++; if (bus.Stolen !== 1'b0) begin n_err++; $display("FAIL rm_stolen got %b want 0", bus.Stolen); end
        bus.HostReq = 1'b0;
        #1 rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus.VgaAddr = 4'(a);
            tick;
            n_cmp++; if (bus.VgaData !== 8'h00) begin n_err++; $display("FAIL rm_bank[%0d] got %h want 00", a, bus.VgaData); end
            n_cmp++; if (bus.HostAck !== 1'b0) begin n_err++; $display("FAIL rm_idle[%0d] got %b want 0", a, bus.HostAck); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.Blank = 1'b0; bus.VgaAddr = '0; bus.HostReq = 1'b0;
        bus.HostWe = 1'b0; bus.HostAddr = '0; bus.HostWData = '0;
        #12 rst_n = 1'b1;
        test_reset;
        test_write;
        test_read;
        test_steal;
        test_abandon;
        test_blank_fall;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Owns the 16 x 8-bit display register bank that the VGA pointer logic reads pixel/character data from.
- The bank is single-ported and is shared between two requesters:
  - the VGA read path, which reads every cycle;
  - a host port (RTC/keyboard update logic) with a 4-phase req/ack handshake.
- Host accesses are normally granted only while Blank=1. A starvation counter forces a one-cycle steal during active video if the host waits too long.

Parameters:
- ADDR_W, 4, bank address width (bank depth = 2^ADDR_W).
- DATA_W, 8, bank word width.
- MAX_WAIT, 800, number of pending-request cycles in IDLE before a forced grant.
- WAIT_W, 10, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Blank  in  1  from SyncCounters; 1 = outside the visible area.
- VgaAddr  in  ADDR_W  read address from the VGA pointers.
- VgaData  out  DATA_W  registered read data to the VGA pointers.
- HostReq  in  1  host request; held high until HostAck is seen.
- HostWe  in  1  1 = write, 0 = read; valid while HostReq=1.
- HostAddr  in  ADDR_W  host address.
- HostWData  in  DATA_W  host write data.
- HostRData  out  DATA_W  host read data; valid while HostAck=1.
- HostAck  out  1  handshake acknowledge.
- Stolen  out  1  one-cycle pulse when a forced grant steals an active-video cycle.

Behaviour:

Reset (RESET=0, asynchronous):
- All bank words = 0, VgaData=0, HostRData=0, HostAck=0, Stolen=0.
- Wait counter = 0, FSM = IDLE, request registers = 0.
- Reset mid-handshake abandons the access; a host write not yet performed is lost.

FSM states: IDLE, ACCESS, ACK.
- IDLE → ACCESS when HostReq=1 and (Blank=1 or waitcnt==MAX_WAIT).
  - HostWe, HostAddr and HostWData are latched into request registers on this edge.
  - Stolen pulses for 1 cycle if the grant was taken with Blank=0.
- ACCESS → ACK unconditionally after 1 cycle.
  - The port belongs to the host for exactly this one cycle.
  - On a write, bank[reqAddr] <= reqWData.
  - On a read, HostRData <= bank[reqAddr].
- In ACK, HostAck=1 (registered).
  - ACK → IDLE on the first edge with HostReq=0; HostAck goes to 0 on that edge.
  - A new request needs HostReq to return low first (4-phase handshake).

Host latency:
- Minimum is 2 edges from the granting edge to HostAck=1.
- HostRData is stable from HostAck rising until the next grant.

Wait counter:
- Increments each cycle the FSM is in IDLE with HostReq=1 and no grant.
- Saturates at MAX_WAIT.
- Clears to 0 on a grant and whenever HostReq=0.

VGA read path:
- In every state except ACCESS: VgaData <= bank[VgaAddr], latency 1 cycle, independent of Blank.
- In the ACCESS cycle, VgaData holds its previous value.
- A write performed in ACCESS is visible to a VGA read of the same address on the next cycle (read-after-write, no bypass needed).

Boundary cases:
- Blank falling while in ACCESS or ACK: the access completes normally. VGA reads resume in ACK/IDLE.
- HostReq dropped in IDLE before a grant: no access is performed and the counter clears.
- HostReq dropped during ACCESS: protocol violation. The access still completes, and ACK exits on the next edge.
- Address wrap: addresses are ADDR_W bits, so no out-of-range case exists.
- No arithmetic overflow exists except the saturating wait counter.

Test Plan:
1. Reset mid-operation: assert RESET=0 while the FSM is in ACCESS → all outputs 0 immediately; after release the FSM is in IDLE and the bank reads back all 0.
2. Blank=1, host write 0xA5 to addr 3 → HostAck=1 two edges after the grant. Drop HostReq → Ack falls next edge. Then Blank=0, VgaAddr=3 → VgaData=0xA5 one cycle later. Stolen stays 0.
3. Blank=1, host read of addr 3 after scenario 2 → HostRData=0xA5 while HostAck=1. HostAck stays high for as long as HostReq is held, e.g. 10 cycles.
4. Blank=0 held, HostReq=1 with MAX_WAIT=800:
   - Expected grant and Stolen pulse exactly 800 cycles after the request entered IDLE.
   - VgaData frozen for exactly one cycle (ACCESS).
   - Ack follows; the counter is back to 0 afterwards.
5. Blank=0 with HostReq pulsed high 5 cycles then low, then Blank=1 → no access, HostAck never asserts, bank unchanged, counter cleared.
6. Blank falls in the same cycle as the grant edge while Blank was 1 → access completes, Stolen=0. VGA reads resume with a 1-cycle gap only.
